ntt_mem_sched: RTL and testbench
================================

NTT_MEM_SCHED -- requirements
Module: ntt_mem_sched

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have ADDR_W, 11, coefficient/twiddle address width.
REQ-002 SHALL have RD_LAT, 1, coefficient RAM and twiddle ROM read latency in cycles.
REQ-003 SHALL have BF_LAT, 4, butterfly datapath latency in cycles; pipeline depth D = RD_LAT+BF_LAT.

Ports (name, direction, width, meaning):
REQ-004 SHALL have clk input 1, single clock; all logic is rising-edge.
REQ-005 SHALL have rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have start input 1, begin a transform; also routed to the index controller.
REQ-007 SHALL have ctrl_index_a / ctrl_index_b / ctrl_index_w input ADDR_W each, current controller indices.
REQ-008 SHALL have ctrl_forward, ctrl_point_mul, ctrl_last_layer, ctrl_done input 1 each, controller status.
REQ-009 SHALL have ctrl_step output 1, advance the index controller.
REQ-010 SHALL have rd_en output 1 and rd_addr_a, rd_addr_b, tw_addr output ADDR_W each, memory read request.
REQ-011 SHALL have bf_valid, bf_forward, bf_point_mul, bf_last_layer output 1 each, butterfly operand-valid and mode, aligned to read data.
REQ-012 SHALL have wr_en output 1 and wr_addr_a, wr_addr_b output ADDR_W each, write-back request aligned to butterfly result.
REQ-013 SHALL have busy output 1 and done output 1 (one-cycle pulse).

Function
REQ-014 SHALL implement FSM IDLE, RUN, DRAIN, FIN; start in any state -> RUN and clears all in-flight entries.
REQ-015 In RUN, when ctrl_done=0 and no hazard: rd_en=1, ctrl_step=1, addresses = ctrl_index_* in the same cycle (combinational issue).
REQ-016 Hazard SHALL be: ctrl_index_a or ctrl_index_b equals wr_addr_a or wr_addr_b of any valid in-flight entry in stages 1..D; on hazard rd_en=0, ctrl_step=0, and the pipeline keeps advancing with a bubble.
REQ-017 In RUN with ctrl_done=1 and ctrl_forward=1 (forward/inverse turnaround): ctrl_step=1, rd_en=0, no entry inserted.
REQ-018 In RUN with ctrl_done=1 and ctrl_forward=0: ctrl_step=0, rd_en=0, -> DRAIN.
REQ-019 DRAIN SHALL hold until all D stages are invalid, then -> FIN; FIN asserts done for exactly one cycle, then -> IDLE.
REQ-020 An entry issued at cycle t SHALL carry {addr_a, addr_b, forward, point_mul, last_layer}; bf_* outputs reflect it at t+RD_LAT; wr_en and wr_addr_* at t+D.
REQ-021 Point-mul entries (addr_a == addr_b) SHALL still write both ports with identical address; the RAM wrapper tolerates this.
REQ-022 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE and FIN.
REQ-023 Addresses SHALL pass unmodified (no arithmetic, no wrap); width ADDR_W throughout.

Reset
REQ-024 On rst_n=0: FSM=IDLE, all stage valids=0, rd_en=ctrl_step=wr_en=bf_valid=busy=done=0, stored addresses=0.
REQ-025 Reset mid-transform SHALL discard in-flight entries; no write-back occurs after rst_n deasserts.

Structure
REQ-026 FSM state encoding and default RD_LAT/BF_LAT SHALL live in shared package ntt_pkg.
REQ-027 In-flight tracking SHALL be one sub-module ntt_inflight_pipe (D-deep valid+payload shift register with hazard comparators).

Verification
REQ-028 Reset: rst_n low 3 cycles -> all outputs 0, FSM IDLE.
REQ-029 Single op: start, indices a=0,b=256,w=3, ctrl_done=0 -> rd_en at t, bf_valid at t+1, wr_en with 0/256 at t+5.
REQ-030 Hazard: issue a=4,b=6; next cycle present a=6,b=7 -> ctrl_step=0 for 5 cycles, issue at cycle t+6.
REQ-031 Turnaround: ctrl_done=1,ctrl_forward=1 -> ctrl_step=1, rd_en=0, stays RUN.
REQ-032 Finish: ctrl_done=1,ctrl_forward=0 with 3 entries in flight -> 3 more wr_en, done one-cycle pulse, busy falls.
REQ-033 Mid-run reset: rst_n low with 4 entries in flight -> no wr_en after release, done never pulses.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT memory scheduler: FSM encoding and default latencies.
package ntt_pkg;

  localparam int NTT_RD_LAT = 1;
  localparam int NTT_BF_LAT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } ntt_state_e;

  function automatic logic state_is_busy(input ntt_state_e s);
    return (s == S_RUN) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/ntt_inflight_pipe.sv
// D-deep shift register of issued butterflies with read-after-write hazard compare.
module ntt_inflight_pipe #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 5,
  parameter int TAP    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_a,
  input  logic [ADDR_W-1:0] push_b,
  input  logic              push_fwd,
  input  logic              push_pm,
  input  logic              push_ll,
  input  logic [ADDR_W-1:0] chk_a,
  input  logic [ADDR_W-1:0] chk_b,
  output logic              hazard,
  output logic              empty,
  output logic              tap_valid,
  output logic              tap_fwd,
  output logic              tap_pm,
  output logic              tap_ll,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_a,
  output logic [ADDR_W-1:0] out_b
);

  logic [DEPTH-1:0]  valid_q, valid_d, fwd_q, fwd_d, pm_q, pm_d, ll_q, ll_d;
  logic [ADDR_W-1:0] a_q [DEPTH];
  logic [ADDR_W-1:0] a_d [DEPTH];
  logic [ADDR_W-1:0] b_q [DEPTH];
  logic [ADDR_W-1:0] b_d [DEPTH];

  always_comb begin
    for (int k = DEPTH - 1; k > 0; k--) begin
      valid_d[k] = valid_q[k-1];
      fwd_d[k]   = fwd_q[k-1];
      pm_d[k]    = pm_q[k-1];
      ll_d[k]    = ll_q[k-1];
      a_d[k]     = a_q[k-1];
      b_d[k]     = b_q[k-1];
    end
    // Bubbles carry a zero payload so idle write addresses read back as 0.
    valid_d[0] = push;
    fwd_d[0]   = push & push_fwd;
    pm_d[0]    = push & push_pm;
    ll_d[0]    = push & push_ll;
    a_d[0]     = push ? push_a : '0;
    b_d[0]     = push ? push_b : '0;
    if (flush) begin
      valid_d = '0;
      fwd_d   = '0;
      pm_d    = '0;
      ll_d    = '0;
      for (int k = 0; k < DEPTH; k++) begin
        a_d[k] = '0;
        b_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      fwd_q   <= '0;
      pm_q    <= '0;
      ll_q    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      fwd_q   <= fwd_d;
      pm_q    <= pm_d;
      ll_q    <= ll_d;
      for (int k = 0; k < DEPTH; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  // Any pending write to either read address blocks the read, including the stage writing now.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[k] && (chk_a == a_q[k] || chk_a == b_q[k] ||
                         chk_b == a_q[k] || chk_b == b_q[k]))
        hazard = 1'b1;
    end
  end

  assign empty     = ~|valid_q;
  assign tap_valid = valid_q[TAP-1];
  assign tap_fwd   = fwd_q[TAP-1];
  assign tap_pm    = pm_q[TAP-1];
  assign tap_ll    = ll_q[TAP-1];
  assign out_valid = valid_q[DEPTH-1];
  assign out_a     = a_q[DEPTH-1];
  assign out_b     = b_q[DEPTH-1];

endmodule

// File: rtl/ntt_mem_sched.sv
// Issues NTT butterfly reads from controller indices, stalls on write-back hazards.
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads, stepping the index controller
// DRAIN | no new issue; waiting for in-flight write-backs
// FIN   | one-cycle done pulse
module ntt_mem_sched import ntt_pkg::*; #(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = NTT_RD_LAT,
  parameter int BF_LAT = NTT_BF_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] ctrl_index_a,
  input  logic [ADDR_W-1:0] ctrl_index_b,
  input  logic [ADDR_W-1:0] ctrl_index_w,
  input  logic              ctrl_forward,
  input  logic              ctrl_point_mul,
  input  logic              ctrl_last_layer,
  input  logic              ctrl_done,
  output logic              ctrl_step,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] tw_addr,
  output logic              bf_valid,
  output logic              bf_forward,
  output logic              bf_point_mul,
  output logic              bf_last_layer,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b,
  output logic              busy,
  output logic              done
);

  localparam int D   = RD_LAT + BF_LAT;
  localparam int TAP = (RD_LAT > 0) ? RD_LAT : 1;
  localparam bit BF_FROM_ISSUE = (RD_LAT == 0);

  ntt_state_e state_q, state_d;
  logic busy_q, busy_d, done_q, done_d;
  logic issue, step;
  logic hazard, pipe_empty;
  logic tap_valid, tap_fwd, tap_pm, tap_ll;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    step    = 1'b0;
    if (start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!ctrl_done) begin
            issue = !hazard;
            step  = !hazard;
          end else if (ctrl_forward) begin
            step = 1'b1;  // forward->inverse turnaround: advance without a read
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: if (pipe_empty) state_d = S_FIN;
        S_FIN:   state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
    busy_d = state_is_busy(state_d);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ntt_inflight_pipe #(
    .ADDR_W (ADDR_W),
    .DEPTH  (D),
    .TAP    (TAP)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start),
    .push      (issue),
    .push_a    (ctrl_index_a),
    .push_b    (ctrl_index_b),
    .push_fwd  (ctrl_forward),
    .push_pm   (ctrl_point_mul),
    .push_ll   (ctrl_last_layer),
    .chk_a     (ctrl_index_a),
    .chk_b     (ctrl_index_b),
    .hazard    (hazard),
    .empty     (pipe_empty),
    .tap_valid (tap_valid),
    .tap_fwd   (tap_fwd),
    .tap_pm    (tap_pm),
    .tap_ll    (tap_ll),
    .out_valid (wr_en),
    .out_a     (wr_addr_a),
    .out_b     (wr_addr_b)
  );

  assign ctrl_step     = step;
  assign rd_en         = issue;
  assign rd_addr_a     = issue ? ctrl_index_a : '0;
  assign rd_addr_b     = issue ? ctrl_index_b : '0;
  assign tw_addr       = issue ? ctrl_index_w : '0;
  assign bf_valid      = BF_FROM_ISSUE ? issue : tap_valid;
  assign bf_forward    = BF_FROM_ISSUE ? (issue & ctrl_forward) : tap_fwd;
  assign bf_point_mul  = BF_FROM_ISSUE ? (issue & ctrl_point_mul) : tap_pm;
  assign bf_last_layer = BF_FROM_ISSUE ? (issue & ctrl_last_layer) : tap_ll;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ntt_mem_sched.sv
// Randomized bench for ntt_mem_sched against a cycle-indexed issue-log reference model.
module tb_ntt_mem_sched;

  localparam int AW   = 11;
  localparam int RDL  = 1;
  localparam int D    = 5;
  localparam int NCYC = 4096;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_FIN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start;
  logic [AW-1:0] ia, ib, iw;
  logic cf, cpm, cll, cdn;
  logic ctrl_step, rd_en, bf_valid, bf_forward, bf_point_mul, bf_last_layer;
  logic wr_en, busy, done;
  logic [AW-1:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;

  ntt_mem_sched #(.ADDR_W(AW), .RD_LAT(1), .BF_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ctrl_index_a(ia), .ctrl_index_b(ib), .ctrl_index_w(iw),
    .ctrl_forward(cf), .ctrl_point_mul(cpm), .ctrl_last_layer(cll), .ctrl_done(cdn),
    .ctrl_step(ctrl_step), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_addr(tw_addr), .bf_valid(bf_valid), .bf_forward(bf_forward),
    .bf_point_mul(bf_point_mul), .bf_last_layer(bf_last_layer),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, m_mode = M_IDLE, next_mode = M_IDLE, last_flush = 0;
  bit iss_v [NCYC];
  logic [AW-1:0] iss_a [NCYC];
  logic [AW-1:0] iss_b [NCYC];
  bit iss_f [NCYC];
  bit iss_pm [NCYC];
  bit iss_ll [NCYC];
  bit o_rd, o_wr, o_done, o_step, o_bf, o_busy;
  int o_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit visible(input int s, input int x);
    if (s < 0 || s >= NCYC) return 1'b0;
    return iss_v[s] && s >= last_flush && s >= x - D && s <= x - 1;
  endfunction

  task automatic eval();
    bit haz, any, exp_issue, exp_step;
    int wi, bi;
    o_rd = rd_en; o_wr = wr_en; o_done = done; o_step = ctrl_step;
    o_bf = bf_valid; o_busy = busy; o_cyc = cyc;
    if (!rst_n) begin
      chk("rst_ctrl", {rd_en, ctrl_step, wr_en, bf_valid, busy, done}, 0);
      chk("rst_bf_mode", {bf_forward, bf_point_mul, bf_last_layer}, 0);
      chk("rst_rd_addr", {rd_addr_a, rd_addr_b, tw_addr}, 0);
      chk("rst_wr_addr", {wr_addr_a, wr_addr_b}, 0);
      next_mode = M_IDLE;
      last_flush = cyc + 1;
      if (cyc < NCYC) iss_v[cyc] = 1'b0;
      return;
    end
    haz = 1'b0; any = 1'b0; wi = -1; bi = -1;
    for (int s = cyc - D; s <= cyc - 1; s++) begin
      if (visible(s, cyc)) begin
        any = 1'b1;
        if (ia == iss_a[s] || ia == iss_b[s] || ib == iss_a[s] || ib == iss_b[s]) haz = 1'b1;
        if (s == cyc - D) wi = s;
        if (s == cyc - RDL) bi = s;
      end
    end
    exp_issue = 1'b0; exp_step = 1'b0; next_mode = m_mode;
    if (start) next_mode = M_RUN;
    else if (m_mode == M_RUN) begin
      if (!cdn) begin
        exp_issue = !haz;
        exp_step = !haz;
      end else if (cf) exp_step = 1'b1;
      else next_mode = M_DRAIN;
    end else if (m_mode == M_DRAIN) begin
      if (!any) next_mode = M_FIN;
    end else if (m_mode == M_FIN) next_mode = M_IDLE;

    chk("rd_en", rd_en, exp_issue);
    chk("ctrl_step", ctrl_step, exp_step);
    if (exp_issue) chk("rd_addr", {rd_addr_a, rd_addr_b, tw_addr}, {ia, ib, iw});
    chk("bf_valid", bf_valid, bi >= 0);
    if (bi >= 0)
      chk("bf_mode", {bf_forward, bf_point_mul, bf_last_layer}, {iss_f[bi], iss_pm[bi], iss_ll[bi]});
    chk("wr_en", wr_en, wi >= 0);
    if (wi >= 0) chk("wr_addr", {wr_addr_a, wr_addr_b}, {iss_a[wi], iss_b[wi]});
    chk("busy", busy, m_mode == M_RUN || m_mode == M_DRAIN);
    chk("done", done, m_mode == M_FIN);
    if (cyc < NCYC) begin
      iss_v[cyc] = exp_issue; iss_a[cyc] = ia; iss_b[cyc] = ib;
      iss_f[cyc] = cf; iss_pm[cyc] = cpm; iss_ll[cyc] = cll;
    end
    if (start) last_flush = cyc;
  endtask

  task automatic tick();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
    cyc++;
    m_mode = next_mode;
  endtask

  task automatic drv(input bit st, input int a, input int b, input int w,
                     input bit f, input bit pm, input bit ll, input bit dn);
    start = st; ia = AW'(a); ib = AW'(b); iw = AW'(w);
    cf = f; cpm = pm; cll = ll; cdn = dn;
  endtask

  task automatic drv_rand_idle();
    drv(1'b0, $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
        1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic finish_xform(output int nwr, output int ndone, output int first_wr);
    bit seen;
    nwr = 0; ndone = 0; first_wr = -1; seen = 1'b0;
    drv(1'b0, $urandom_range(0, 2047), $urandom_range(0, 2047), 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (o_wr) begin
        nwr++;
        if (first_wr < 0) first_wr = o_cyc;
      end
      if (o_done) begin
        ndone++;
        seen = 1'b1;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    tick();
    if (o_done) ndone++;
    chk("busy_after_done", o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, gap, nwr, ndone, fw, a, len, cnt_wr, cnt_done;
    drv(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin drv_rand_idle(); tick(); end
    rst_n = 1'b1;
    drv(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // single op: a=0, b=256, w=3
    drv(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    t0 = cyc;
    drv(1'b0, 0, 256, 3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("op_issue", o_rd, 1);
    drv(1'b0, 0, 256, 3, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk("op_bf_lat", o_bf, 1);
    finish_xform(nwr, ndone, fw);
    chk("op_wr_lat", fw - t0, 5);
    chk("op_wr_cnt", nwr, 1);

    // hazard: a=6 collides with in-flight b=6; then turnaround
    drv(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drv(1'b0, 4, 6, 1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("haz_first_issue", o_rd, 1);
    drv(1'b0, 6, 7, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    gap = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (o_rd) begin gap = k; break; end
      if (o_step) gap = -k;
    end
    chk("haz_gap", gap, 6);
    drv(1'b0, 9, 9, 0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    chk("turn_step", o_step, 1);
    chk("turn_rd", o_rd, 0);
    drv(1'b0, 100, 101, 5, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("turn_stays_run", o_busy, 1);
    finish_xform(nwr, ndone, fw);
    chk("turn_done_pulse", ndone, 1);

    // finish with three entries in flight
    drv(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    for (int k = 1; k <= 3; k++) begin
      drv(1'b0, 10 * k, 10 * k + 1, k, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    end
    finish_xform(nwr, ndone, fw);
    chk("fin_wr_cnt", nwr, 3);
    chk("fin_done_cnt", ndone, 1);

    // reset with four entries in flight
    drv(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, 40 + 2 * k, 41 + 2 * k, k, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    end
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    cnt_wr = 0; cnt_done = 0;
    for (int k = 0; k < 10; k++) begin
      drv(1'b0, 40, 41, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      if (o_wr) cnt_wr++;
      if (o_done) cnt_done++;
    end
    chk("rst_mid_wr", cnt_wr, 0);
    chk("rst_mid_done", cnt_done, 0);

    // randomized transforms
    for (int x = 0; x < 8; x++) begin
      repeat ($urandom_range(1, 4)) begin drv_rand_idle(); tick(); end
      drv(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      len = $urandom_range(30, 70);
      for (int k = 0; k < len; k++) begin
        a = $urandom_range(0, 15);
        if ($urandom_range(0, 99) < 15)
          drv(1'b0, a, a, $urandom_range(0, 2047), 1'($urandom), 1'b1, 1'($urandom), 1'b0);
        else if ($urandom_range(0, 99) < 8)
          drv(1'b0, a, $urandom_range(0, 2047), 0, 1'b1, 1'b0, 1'b0, 1'b1);
        else
          drv(1'b0, a, $urandom_range(0, 15) + 16 * $urandom_range(0, 1), $urandom_range(0, 2047),
              1'($urandom), 1'b0, 1'($urandom), 1'b0);
        if ($urandom_range(0, 99) < 2) start = 1'b1;
        tick();
      end
      finish_xform(nwr, ndone, fw);
      chk("rand_done_cnt", ndone, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
